// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// FSM state encoding and the halt sentinel word.
package fetch_unit_pkg;

  localparam int unsigned FU_ADDR_WIDTH = 10;
  localparam int unsigned FU_RESET_PC   = 0;
  localparam int unsigned FU_FIFO_DEPTH = 2;
  localparam int unsigned INSTR_WIDTH   = 32;

  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Show-ahead synchronous FIFO for fetched {pc, instr} entries, with a
// single-cycle flush used on redirects.
module fetch_fifo #(
  parameter int unsigned DW    = 42,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [DW-1:0]          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (i_push && !i_pop && !i_flush) |-> (r_count < CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (i_pop && !i_flush) |-> (r_count != '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited reads to a
// 1-cycle synchronous imem, buffers returns. Optional halt: FETCH_HALT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FU_ADDR_WIDTH,
  parameter int unsigned RESET_PC   = FU_RESET_PC,
  parameter int unsigned FIFO_DEPTH = FU_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr
);

  localparam int unsigned EW = ADDR_WIDTH + INSTR_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [EW-1:0]         w_head;
  logic [OW-1:0]         w_occ;
  logic [OW-1:0]         w_limit;

  assign w_pop = instr_valid & instr_ready;

  // Credit check: buffered + in-flight words after this cycle's pop must
  // leave room, so a returning word can never land on a full FIFO.
  assign w_occ   = OW'(w_count) + OW'(r_inflight);
  assign w_limit = OW'(FIFO_DEPTH) + OW'(w_pop);

  always_comb begin
    w_issue = 1'b0;
    if (r_state == ST_RUN && !redirect_valid && (w_occ < w_limit))
      w_issue = 1'b1;
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;

`ifdef FETCH_HALT_EN
  assign w_push = r_inflight & ~redirect_valid & (r_state != ST_HALTED);
`else
  assign w_push = r_inflight & ~redirect_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= ADDR_WIDTH'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (redirect_valid) begin
        r_state <= ST_RUN;
        r_pc    <= redirect_addr;
      end else begin
        case (r_state)
          ST_BOOT: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_issue) r_pc <= r_pc + ADDR_WIDTH'(1);
`ifdef FETCH_HALT_EN
            if (w_push && imem_rdata == HALT_WORD) r_state <= ST_HALTED;
`endif
          end
          ST_HALTED: r_state <= ST_HALTED;
          default:   r_state <= ST_BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({r_inflight_pc, imem_rdata}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  assign instr_valid = ~w_empty;
  assign instr_data  = instr_valid ? w_head[INSTR_WIDTH-1:0]  : '0;
  assign instr_pc    = instr_valid ? w_head[EW-1:INSTR_WIDTH] : '0;

  a_redirect_blocks_req: assert property (@(posedge clk) disable iff (!rst_n)
    redirect_valid |-> !imem_req);

endmodule
